// File: rtl/noise_channel_ctrl_pkg.sv
// Shared types and constants for the noise voice sequencer.
package noise_ctrl_pkg;

  localparam int unsigned DIV_W_DEF  = 16;
  localparam int unsigned HOLD_W_DEF = 8;

  localparam logic [7:0] VOL_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DECAY
  } state_e;

endpackage

// File: rtl/noise_channel_ctrl_step_divider.sv
// Step-period counter: ticks once every (period+1) cycles while running.
module step_divider
  import noise_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  // A clear swallows a coinciding tick so a restart never emits a stale step.
  always_comb begin
    tick      = 1'b0;
    div_cnt_d = div_cnt_q;
    if (clr || !run) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == period) begin
      tick      = 1'b1;
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/noise_channel_ctrl.sv
// Noise voice sequencer: trigger-started burst, paced LFSR step-enable and
// hold-then-linear-decay volume envelope applied to the noise sample.
module noise_channel_ctrl
  import noise_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned HOLD_W = HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [DIV_W-1:0]  period,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic [7:0]        decay_rate,
  input  logic [7:0]        noise_in,
  output logic              noise_step,
  output logic [7:0]        sample_out,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [7:0]         vol_q, vol_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic [HOLD_W-1:0]  hold_len_q, hold_len_d;
  logic [7:0]         rate_q, rate_d;
  logic               noise_step_q, noise_step_d;
  logic [7:0]         sample_q, sample_d;

  logic               tick;
  logic [HOLD_W:0]    hold_next;
  logic [7:0]         scaled;

  step_divider #(
    .DIV_W (DIV_W)
  ) u_step_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_q != IDLE),
    .clr    (trig),
    .period (period_q),
    .tick   (tick)
  );

  assign hold_next = {1'b0, hold_cnt_q} + 1'b1;
  assign scaled    = 8'((16'(noise_in) * 16'(vol_q)) >> 8);

  always_comb begin
    state_d      = state_q;
    vol_d        = vol_q;
    hold_cnt_d   = hold_cnt_q;
    period_d     = period_q;
    hold_len_d   = hold_len_q;
    rate_d       = rate_q;
    noise_step_d = tick;

    if (trig) begin
      period_d   = period;
      hold_len_d = hold_len;
      rate_d     = (decay_rate == 8'd0) ? 8'd1 : decay_rate;
      vol_d      = VOL_MAX;
      hold_cnt_d = '0;
      state_d    = PLAY;
    end else if (tick) begin
      unique case (state_q)
        PLAY: begin
          if (hold_next >= {1'b0, hold_len_q}) begin
            state_d = DECAY;
          end else begin
            hold_cnt_d = hold_next[HOLD_W-1:0];
          end
        end
        DECAY: begin
          if (vol_q > rate_q) begin
            vol_d = vol_q - rate_q;
          end else begin
            vol_d   = '0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    // Gating on the next state keeps the registered sample at 0 for every cycle spent in IDLE.
    sample_d = (state_d == IDLE) ? '0 : scaled;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vol_q        <= '0;
      hold_cnt_q   <= '0;
      period_q     <= '0;
      hold_len_q   <= '0;
      rate_q       <= 8'd1;
      noise_step_q <= 1'b0;
      sample_q     <= '0;
    end else begin
      state_q      <= state_d;
      vol_q        <= vol_d;
      hold_cnt_q   <= hold_cnt_d;
      period_q     <= period_d;
      hold_len_q   <= hold_len_d;
      rate_q       <= rate_d;
      noise_step_q <= noise_step_d;
      sample_q     <= sample_d;
    end
  end

  assign noise_step = noise_step_q;
  assign sample_out = sample_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_noise_channel_ctrl.sv
// Self-checking bench for noise_channel_ctrl against a closed-form burst model.
module tb_noise_channel_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] period = '0;
  logic [7:0]  hold_len = '0;
  logic [7:0]  decay_rate = '0;
  logic [7:0]  noise_in = '0;
  logic        noise_step;
  logic [7:0]  sample_out;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  noise_channel_ctrl #(.DIV_W(16), .HOLD_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig       (trig),
    .period     (period),
    .hold_len   (hold_len),
    .decay_rate (decay_rate),
    .noise_in   (noise_in),
    .noise_step (noise_step),
    .sample_out (sample_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Burst model: cycles elapsed since trig determine step count k, and
  // volume is a closed-form function of k.
  bit         m_active = 1'b0;
  int         m_c, m_p, m_h, m_r, m_n;
  int         m_vol = 0;
  bit         e_step = 1'b0;
  bit         e_busy = 1'b0;
  logic [7:0] e_sample = '0;

  function automatic int vol_at(int k);
    int v;
    if (k <= m_h) return 255;
    v = 255 - (k - m_h) * m_r;
    return (v < 0) ? 0 : v;
  endfunction

  task automatic step_clk();
    logic rs   = rst_n;
    logic t    = trig;
    int   nz   = int'(noise_in);
    int   vb   = m_vol;
    int   p_in = int'(period);
    int   h_in = int'(hold_len);
    int   r_in = int'(decay_rate);
    int   k;
    @(posedge clk);
    #1;
    if (!rs) begin
      m_active = 1'b0; m_vol = 0; e_step = 1'b0; e_busy = 1'b0;
    end else if (t) begin
      m_active = 1'b1;
      m_c = 0;
      m_p = p_in;
      m_h = (h_in == 0) ? 1 : h_in;
      m_r = (r_in == 0) ? 1 : r_in;
      m_n = m_h + (255 + m_r - 1) / m_r;
      m_vol = 255;
      e_step = 1'b0;
      e_busy = 1'b1;
    end else if (m_active) begin
      m_c++;
      k = m_c / (m_p + 1);
      e_step = (m_c % (m_p + 1) == 0);
      m_vol = vol_at(k);
      e_busy = (k < m_n);
      if (!e_busy) m_active = 1'b0;
    end else begin
      e_step = 1'b0;
      e_busy = 1'b0;
    end
    e_sample = (rs && e_busy) ? 8'((nz * vb) >> 8) : 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trig  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      tests_run++;
      if ({noise_step, busy, sample_out} !== {1'b0, 1'b0, 8'h00}) begin
        tests_failed++;
        $display("FAIL reset_hold cyc=%0d got step=%b busy=%b sample=%02h, expected 0 0 00", i, noise_step, busy, sample_out);
      end
    end
    rst_n = 1'b1;
    noise_in = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      step_clk();
      tests_run++;
      if ({noise_step, busy, sample_out} !== {e_step, e_busy, e_sample}) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d got step=%b busy=%b sample=%02h, expected %b %b %02h", i, noise_step, busy, sample_out, e_step, e_busy, e_sample);
      end
    end
  endtask

  task automatic test_standard_burst();
    int pulses = 0;
    int busy_cycles = 0;
    period = 16'd3; hold_len = 8'd2; decay_rate = 8'h40; noise_in = 8'hFF;
    trig = 1'b1;
    step_clk();
    trig = 1'b0;
    // Input changes after trig must not affect the burst.
    period = 16'($urandom_range(0, 9)); hold_len = 8'($urandom); decay_rate = 8'($urandom);
    if (busy) busy_cycles++;
    for (int i = 1; i <= 40; i++) begin
      step_clk();
      if (noise_step) pulses++;
      if (busy) busy_cycles++;
      tests_run++;
      if ({noise_step, busy, sample_out} !== {e_step, e_busy, e_sample}) begin
        tests_failed++;
        $display("FAIL std_burst cyc=%0d got step=%b busy=%b sample=%02h, expected %b %b %02h", i, noise_step, busy, sample_out, e_step, e_busy, e_sample);
      end
    end
    tests_run++;
    if (pulses !== 6) begin
      tests_failed++;
      $display("FAIL std_pulse_count got %0d, expected 6", pulses);
    end
    tests_run++;
    if (busy_cycles !== 24) begin
      tests_failed++;
      $display("FAIL std_busy_cycles got %0d, expected 24", busy_cycles);
    end
  endtask

  task automatic test_scaling();
    period = 16'd3; hold_len = 8'd200; decay_rate = 8'd1; noise_in = 8'h80;
    trig = 1'b1;
    step_clk();
    trig = 1'b0;
    step_clk();
    tests_run++;
    if (sample_out !== 8'h7F) begin
      tests_failed++;
      $display("FAIL scale_80 got %02h, expected 7f", sample_out);
    end
    noise_in = 8'hFF;
    step_clk();
    tests_run++;
    if (sample_out !== 8'hFE) begin
      tests_failed++;
      $display("FAIL scale_ff got %02h, expected fe", sample_out);
    end
    // Fast decay by 0x20 per cycle: vol reaches 0x3F after the seventh step.
    period = 16'd0; hold_len = 8'd0; decay_rate = 8'h20;
    trig = 1'b1;
    step_clk();
    trig = 1'b0;
    for (int i = 0; i < 8; i++) step_clk();
    tests_run++;
    if (sample_out !== 8'h3E) begin
      tests_failed++;
      $display("FAIL scale_3f got %02h, expected 3e", sample_out);
    end
    for (int i = 0; i < 20 && busy; i++) step_clk();
  endtask

  task automatic test_retrigger();
    int gap = -1;
    period = 16'd3; hold_len = 8'd2; decay_rate = 8'h40; noise_in = 8'hFF;
    trig = 1'b1;
    step_clk();
    trig = 1'b0;
    for (int i = 1; i < 20; i++) step_clk();
    tests_run++;
    if (sample_out !== 8'h7E) begin
      tests_failed++;
      $display("FAIL retrig_pre_vol got sample=%02h, expected 7e", sample_out);
    end
    // Retrigger on the edge where the fifth step event would fall.
    trig = 1'b1;
    step_clk();
    trig = 1'b0;
    tests_run++;
    if ({noise_step, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL retrig_swallow got step=%b busy=%b, expected 0 1", noise_step, busy);
    end
    for (int i = 1; i <= 30; i++) begin
      step_clk();
      if (noise_step && gap < 0) gap = i;
      tests_run++;
      if ({noise_step, busy, sample_out} !== {e_step, e_busy, e_sample}) begin
        tests_failed++;
        $display("FAIL retrig cyc=%0d got step=%b busy=%b sample=%02h, expected %b %b %02h", i, noise_step, busy, sample_out, e_step, e_busy, e_sample);
      end
    end
    tests_run++;
    if (gap !== 4) begin
      tests_failed++;
      $display("FAIL retrig_gap got %0d, expected 4", gap);
    end
  endtask

  task automatic test_edge_params();
    int pulses = 0;
    int busy_cycles = 0;
    int cyc = 0;
    period = 16'd0; hold_len = 8'd0; decay_rate = 8'd0;
    trig = 1'b1;
    step_clk();
    trig = 1'b0;
    while (busy && cyc < 400) begin
      busy_cycles++;
      noise_in = 8'($urandom);
      step_clk();
      cyc++;
      if (noise_step) pulses++;
      tests_run++;
      if ({noise_step, busy, sample_out} !== {e_step, e_busy, e_sample}) begin
        tests_failed++;
        $display("FAIL edge cyc=%0d got step=%b busy=%b sample=%02h, expected %b %b %02h", cyc, noise_step, busy, sample_out, e_step, e_busy, e_sample);
      end
    end
    // One hold step plus 255 unit decrements.
    tests_run++;
    if (busy_cycles !== 256) begin
      tests_failed++;
      $display("FAIL edge_busy_cycles got %0d, expected 256", busy_cycles);
    end
    tests_run++;
    if (pulses !== 256) begin
      tests_failed++;
      $display("FAIL edge_pulses got %0d, expected 256", pulses);
    end
  endtask

  task automatic test_async_reset();
    period = 16'd3; hold_len = 8'd5; decay_rate = 8'h10; noise_in = 8'hFF;
    trig = 1'b1;
    step_clk();
    trig = 1'b0;
    for (int i = 0; i < 4; i++) step_clk();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({noise_step, busy, sample_out} !== {1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL async_reset got step=%b busy=%b sample=%02h, expected 0 0 00", noise_step, busy, sample_out);
    end
    step_clk();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step_clk();
      tests_run++;
      if ({noise_step, busy, sample_out} !== {e_step, e_busy, e_sample}) begin
        tests_failed++;
        $display("FAIL post_reset cyc=%0d got step=%b busy=%b sample=%02h, expected %b %b %02h", i, noise_step, busy, sample_out, e_step, e_busy, e_sample);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      noise_in = 8'($urandom);
      trig = ((!busy && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0);
      if (trig || $urandom_range(0, 3) == 0) begin
        period     = 16'($urandom_range(0, 4));
        hold_len   = 8'($urandom_range(0, 6));
        decay_rate = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      end
      step_clk();
      tests_run++;
      if ({noise_step, busy, sample_out} !== {e_step, e_busy, e_sample}) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got step=%b busy=%b sample=%02h, expected %b %b %02h", i, noise_step, busy, sample_out, e_step, e_busy, e_sample);
      end
    end
    trig = 1'b0;
  endtask

  initial begin
    test_reset();
    test_standard_burst();
    test_scaling();
    test_retrigger();
    test_edge_params();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
